// File: rtl/alu_pipe_param.sv
// alu_pipe_param: two-stage pipelined ALU with valid/ready handshake.
// Stage 1 captures operands; stage 2 computes and registers result and flags.
module alu_pipe_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] abus,
    input  logic [WIDTH-1:0] bbus,
    input  logic [2:0]       S,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dbus,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N
);

    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [2:0]       s1;
    logic             c1;
    logic             adv2;
    logic             load1;
    logic             load2;

    assign adv2      = !v2 || out_ready;
    assign in_ready  = !v1 || adv2;
    assign load1     = in_valid && in_ready;
    assign load2     = v1 && adv2;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            s1 <= '0;
            c1 <= 1'b0;
        end else begin
            if (in_ready)
                v1 <= in_valid;
            if (load1) begin
                a1 <= abus;
                b1 <= bbus;
                s1 <= S;
                c1 <= Cin;
            end
        end
    end

    logic             is_sub;
    logic             cin_e;
    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] low;
    logic             c_msb;
    logic             cout_a;
    logic             v_a;
    logic             lt;
    logic [7:0]       op;

    // sub and slt share the inverted-B adder path; slt forces carry-in
    assign is_sub = (s1 == 3'b011) || (s1 == 3'b111);
    assign cin_e  = (s1 == 3'b111) ? 1'b1 : c1;
    assign bop    = is_sub ? ~b1 : b1;
    assign sum    = {1'b0, a1} + {1'b0, bop}
                  + {{WIDTH{1'b0}}, cin_e};
    assign low    = {1'b0, a1[WIDTH-2:0]}
                  + {1'b0, bop[WIDTH-2:0]}
                  + {{(WIDTH-1){1'b0}}, cin_e};
    assign c_msb  = low[WIDTH-1];
    assign cout_a = sum[WIDTH];
    assign v_a    = c_msb ^ cout_a;
    assign lt     = sum[WIDTH-1] ^ v_a;
    assign op     = 8'd1 << s1;

    logic [WIDTH-1:0] r;
    logic             rc;
    logic             rv;

    always_comb begin
        r  = '0;
        rc = 1'b0;
        rv = 1'b0;
        unique case (1'b1)
            op[0]: r = a1 ^ b1;
            op[1]: r = ~(a1 ^ b1);
            op[2]: begin
                r  = sum[WIDTH-1:0];
                rc = cout_a;
                rv = v_a;
            end
            op[3]: begin
                r  = sum[WIDTH-1:0];
                rc = cout_a;
                rv = v_a;
            end
            op[4]: r = a1 | b1;
            op[5]: r = ~(a1 | b1);
            op[6]: r = a1 & b1;
            op[7]: r = {{(WIDTH-1){1'b0}}, lt};
            default: r = 'x;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            dbus <= '0;
            Cout <= 1'b0;
            V    <= 1'b0;
            Z    <= 1'b0;
            N    <= 1'b0;
        end else begin
            if (adv2)
                v2 <= v1;
            if (load2) begin
                dbus <= r;
                Cout <= rc;
                V    <= rv;
                Z    <= (r == '0);
                N    <= r[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param: scoreboard bench for 32-bit and 8-bit instances.
// Stimulus pushes expected results; monitors pop on each output transfer.
module tb_alu_pipe_param;

    typedef struct {
        logic [63:0] d;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic [31:0] abus32 = '0;
    logic [31:0] bbus32 = '0;
    logic [2:0]  s32 = '0;
    logic        cin32 = 1'b0;
    logic        out_valid32;
    logic        out_ready32 = 1'b1;
    logic [31:0] dbus32;
    logic        cout32, v32, z32, n32;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  abus8 = '0;
    logic [7:0]  bbus8 = '0;
    logic [2:0]  s8 = '0;
    logic        cin8 = 1'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  dbus8;
    logic        cout8, v8, z8, n8;

    alu_pipe_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .abus(abus32), .bbus(bbus32), .S(s32), .Cin(cin32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .dbus(dbus32), .Cout(cout32), .V(v32), .Z(z32), .N(n32)
    );

    alu_pipe_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .abus(abus8), .bbus(bbus8), .S(s8), .Cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .dbus(dbus8), .Cout(cout8), .V(v8), .Z(z8), .N(n8)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t q32[$];
    exp_t q8[$];
    int pops32[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [63:0] d, input logic c,
                                input logic v, input logic z,
                                input logic n);
        exp_t e;
        e.d = d; e.c = c; e.v = v; e.z = z; e.n = n;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid32 && out_ready32) begin
            checks++;
            if (q32.size() == 0) begin
                failures++;
                $display("FAIL mon32: unexpected result %h", dbus32);
            end else begin
                exp_t e;
                e = q32.pop_front();
                pops32.push_back(cyc);
                if (dbus32 !== e.d[31:0] || cout32 !== e.c || v32 !== e.v
                    || z32 !== e.z || n32 !== e.n) begin
                    failures++;
                    $display("FAIL mon32: got d=%h c%b v%b z%b n%b expected d=%h c%b v%b z%b n%b",
                             dbus32, cout32, v32, z32, n32,
                             e.d[31:0], e.c, e.v, e.z, e.n);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL mon8: unexpected result %h", dbus8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                if (dbus8 !== e.d[7:0] || cout8 !== e.c || v8 !== e.v
                    || z8 !== e.z || n8 !== e.n) begin
                    failures++;
                    $display("FAIL mon8: got d=%h c%b v%b z%b n%b expected d=%h c%b v%b z%b n%b",
                             dbus8, cout8, v8, z8, n8,
                             e.d[7:0], e.c, e.v, e.z, e.n);
                end
            end
        end
    end

    task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] s, input logic c,
                           input exp_t e, output int waited);
        abus32 = a; bbus32 = b; s32 = s; cin32 = c;
        in_valid32 = 1'b1;
        waited = 0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready32) break;
            waited++;
        end
        checks++;
        if (!in_ready32) begin
            failures++;
            $display("FAIL accept32: in_ready stuck at %b, required 1", in_ready32);
        end
        q32.push_back(e);
        @(posedge clk);
        #1 in_valid32 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] s, input logic c,
                          input exp_t e);
        abus8 = a; bbus8 = b; s8 = s; cin8 = c;
        in_valid8 = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready8) break;
        end
        checks++;
        if (!in_ready8) begin
            failures++;
            $display("FAIL accept8: in_ready stuck at %b, required 1", in_ready8);
        end
        q8.push_back(e);
        @(posedge clk);
        #1 in_valid8 = 1'b0;
    endtask

    int w;
    int w3;

    initial begin
        #2;
        chk("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("rst_dbus", {32'd0, dbus32}, 64'd0);
        chk("rst_flags", {60'd0, cout32, v32, z32, n32}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", {63'd0, in_ready32}, 64'd1);

        // single add with latency check
        issue32(32'h7FFFFFFF, 32'h0, 3'b010, 1'b1,
                mk(64'h80000000, 1'b0, 1'b1, 1'b0, 1'b1), w);
        #1 chk("lat_not_yet", {63'd0, out_valid32}, 64'd0);
        @(posedge clk);
        #1 chk("lat_valid", {63'd0, out_valid32}, 64'd1);
        @(posedge clk); #1;

        issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 1'b0,
                mk(64'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1), w);
        issue32(32'h80000000, 32'h80000000, 3'b010, 1'b0,
                mk(64'h0, 1'b1, 1'b1, 1'b1, 1'b0), w);
        repeat (3) @(posedge clk); #1;

        // back-to-back at full rate
        pops32.delete();
        issue32(32'hF01010CA, 32'hF00011AC, 3'b000, 1'b0,
                mk(64'h00100166, 1'b0, 1'b0, 1'b0, 1'b0), w);
        chk("b2b_wait0", w, 0);
        issue32(32'hF101CBA9, 32'h0011ADC1, 3'b001, 1'b0,
                mk(64'h0EEF9997, 1'b0, 1'b0, 1'b0, 1'b0), w);
        chk("b2b_wait1", w, 0);
        issue32(32'h31312020, 32'hCCEEDDFF, 3'b011, 1'b1,
                mk(64'h64424221, 1'b0, 1'b0, 1'b0, 1'b0), w);
        chk("b2b_wait2", w, 0);
        repeat (3) @(posedge clk); #1;
        chk("b2b_count", pops32.size(), 3);
        if (pops32.size() == 3) begin
            chk("b2b_gap01", pops32[1] - pops32[0], 1);
            chk("b2b_gap12", pops32[2] - pops32[1], 1);
        end

        // backpressure
        out_ready32 = 1'b0;
        issue32(32'h0000F0F0, 32'h0F0F0000, 3'b100, 1'b0,
                mk(64'h0F0FF0F0, 1'b0, 1'b0, 1'b0, 1'b0), w);
        issue32(32'h0, 32'h0, 3'b101, 1'b0,
                mk(64'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1), w);
        @(negedge clk);
        chk("bp_in_ready", {63'd0, in_ready32}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid32}, 64'd1);
        fork
            issue32(32'hFFFF0000, 32'h12345678, 3'b110, 1'b0,
                    mk(64'h12340000, 1'b0, 1'b0, 1'b0, 1'b0), w3);
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("bp_hold", {32'd0, dbus32}, 64'h0F0FF0F0);
                end
                @(posedge clk);
                #1 out_ready32 = 1'b1;
            end
        join
        chk("bp_stalled", {63'd0, (w3 > 0)}, 64'd1);

        issue32(32'hFFFFFFFF, 32'h00000001, 3'b111, 1'b0,
                mk(64'h1, 1'b0, 1'b0, 1'b0, 1'b0), w);

        // WIDTH=8 instance
        issue8(8'h80, 8'h01, 3'b111, 1'b0, mk(64'h01, 1'b0, 1'b0, 1'b0, 1'b0));
        issue8(8'h01, 8'h80, 3'b111, 1'b0, mk(64'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        issue8(8'hFF, 8'h01, 3'b010, 1'b0, mk(64'h00, 1'b1, 1'b0, 1'b1, 1'b0));
        repeat (4) @(posedge clk); #1;

        // reset mid-stream
        out_ready32 = 1'b0;
        issue32(32'h11111111, 32'h22222222, 3'b010, 1'b0,
                mk(64'h33333333, 1'b0, 1'b0, 1'b0, 1'b0), w);
        issue32(32'h5, 32'h3, 3'b110, 1'b0,
                mk(64'h1, 1'b0, 1'b0, 1'b0, 1'b0), w);
        #2 rst_n = 1'b0;
        q32.delete();
        #1;
        chk("mid_rst_valid", {63'd0, out_valid32}, 64'd0);
        chk("mid_rst_dbus", {32'd0, dbus32}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready32}, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready32 = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_stale", {63'd0, out_valid32}, 64'd0);

        for (int t = 0; t < 100; t++) begin
            if (q32.size() == 0 && q8.size() == 0) break;
            @(posedge clk);
        end
        chk("drain32", q32.size(), 0);
        chk("drain8", q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
- Parametrised successor to the fixed 32-bit two-stage pipelined ALU.
- Width is configurable and operands, opcode and carry-in are all captured in the same cycle.
- Valid/ready handshake gives backpressure; result carries Cout, V, Z and N flags; adds signed set-less-than op.
- Sits between the register-file read stage and the writeback/flag logic of the datapath.

Parameters:
WIDTH, 32, operand/result width in bits (legal 4..64)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set presented this cycle
in_ready  output  1  block can accept operand set this cycle
abus  input  WIDTH  operand A
bbus  input  WIDTH  operand B
S  input  3  opcode
Cin  input  1  carry-in (add/sub only)
out_valid  output  1  dbus/flags hold a valid result
out_ready  input  1  downstream accepts result this cycle
dbus  output  WIDTH  result
Cout  output  1  carry out of MSB
V  output  1  signed overflow
Z  output  1  dbus == 0
N  output  1  dbus[WIDTH-1]

Behaviour:
- Reset (rst_n low, asynchronous): stage valid bits v1 and v2 clear. out_valid=0, dbus=0, Cout=V=Z=N=0, in_ready=1 once released. In-flight operations are discarded, including on reset mid-stream.
- Stage 1 registers abus, bbus, S and Cin.
- Stage 2 computes the result and registers dbus and the flags.
- Latency: an operation accepted at edge k gives out_valid=1 after edge k+1, i.e. 2 cycles from presentation to visible result.
- Handshake:
  - Transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
  - adv2 = !v2 || out_ready. in_ready = !v1 || adv2 (combinational path from out_ready is allowed).
  - Bubbles collapse: an empty stage always loads.
  - Stalled stages hold all data bits unchanged.
  - Simultaneous accept and drain in the same cycle sustains 1 op/cycle.
  - Inputs are ignored when in_valid=0 or in_ready=0.
- Opcodes:
  - 000 A^B; 001 ~(A^B); 100 A|B; 101 ~(A|B); 110 A&B. For these five logic ops, Cout=V=0.
  - 010 add: A+B+Cin.
  - 011 sub: A+~B+Cin. Cin=1 gives true A-B.
  - 111 slt: dbus = {0..0, A<B signed}, computed as A+~B+1 with sign xor overflow; Cout=V=0.
- Add/sub flags: Cout = carry out of bit WIDTH-1. V = carry into MSB xor carry out of MSB. All arithmetic is modulo 2^WIDTH.
- Z and N are always derived from the registered dbus, for every opcode.
- Opcode X/Z on an accepted op gives dbus=X. Flags need not be defined.
- out_valid deasserts only after an output transfer with no new op behind it.

Test Plan:
- Reset then single add, WIDTH=32: A=7FFFFFFF, B=0, Cin=1, S=010 -> 2 cycles later dbus=80000000, V=1, Cout=0, N=1, Z=0.
- Carry chain: A=FFFFFFFF, B=FFFFFFFF, Cin=0, add -> dbus=FFFFFFFE, Cout=1, V=0. Then A=B=80000000 -> dbus=0, Cout=1, V=1, Z=1.
- Back-to-back logic/sub with out_ready=1:
  - xor F01010CA,F00011AC -> 00100166
  - xnor F101CBA9,0011ADC1 -> 0EEF9997
  - sub 31312020,CCEEDDFF, Cin=1 -> 64424221
  - Results on consecutive cycles; in_ready stays 1.
- Backpressure: issue 3 ops, hold out_ready=0 -> in_ready drops after 2 accepted, dbus holds first result. Release -> results drain in order, none lost or duplicated.
- slt and WIDTH=8 instance:
  - A=80, B=01 -> dbus=01.
  - A=01, B=80 -> dbus=00.
  - Add FF+01 -> dbus=00, Cout=1, Z=1.
- Reset mid-stream: assert rst_n=0 with v1=v2=1 -> out_valid=0 and dbus=0 immediately (asynchronous). No stale result appears after release.
